// File: rtl/cam_pwr_seq_if.sv
// Control and pin bundle of the camera power-up sequencer.
// The sequencer uses the slave view: it takes requests and drives pins/status.
// The controlling side (top-level control, loader, bench) uses the master view.
interface cam_pwr_seq_if;
   logic       start;
   logic       stop;
   logic       cfg_done;
   logic       cam_pwdn;
   logic       cam_resetn;
   logic       xclk_en;
   logic       cfg_start;
   logic       ready;
   logic       err;
   logic [2:0] state;

   modport slave (
      input  start,
      input  stop,
      input  cfg_done,
      output cam_pwdn,
      output cam_resetn,
      output xclk_en,
      output cfg_start,
      output ready,
      output err,
      output state
   );

   modport master (
      output start,
      output stop,
      output cfg_done,
      input  cam_pwdn,
      input  cam_resetn,
      input  xclk_en,
      input  cfg_start,
      input  ready,
      input  err,
      input  state
   );
endinterface

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer.
// Walks the sensor through power-down release, reset release and settle, launches the
// register loader with a one-cycle cfg_start and waits for cfg_done (with timeout).
// A local prescaler produces a 1 us tick; prescaler and us timer restart on every state
// entry so each timed state lasts exactly T*CLKDIV clock cycles.
module cam_pwr_seq #(
   parameter int unsigned CLKDIV    = 50,
   parameter int unsigned T_PWUP_US = 1000,
   parameter int unsigned T_RST_US  = 20000,
   parameter int unsigned T_CFG_US  = 50000,
   parameter int unsigned US_W      = 16
) (
   input  logic          clk_in,
   input  logic          reset,
   cam_pwr_seq_if.slave  bus
);

   // State encoding, also exported on the debug state port.
   localparam logic [2:0] ST_OFF      = 3'd0;
   localparam logic [2:0] ST_PWR_UP   = 3'd1;
   localparam logic [2:0] ST_RST_WAIT = 3'd2;
   localparam logic [2:0] ST_CFG      = 3'd3;
   localparam logic [2:0] ST_READY    = 3'd4;
   localparam logic [2:0] ST_ERROR    = 3'd5;

   // Prescaler width; CLKDIV is at least 2 so clog2 is at least 1.
   localparam int unsigned PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKDIV - 1);
   localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
   localparam logic [PW-1:0]   PRESC_ZERO = {PW{1'b0}};
   localparam logic [US_W-1:0] US_ONE     = US_W'(1);
   localparam logic [US_W-1:0] US_ZERO    = {US_W{1'b0}};

   // Timer value on which the limiting tick of each timed state occurs.
   localparam logic [US_W-1:0] PWUP_LAST  = US_W'(T_PWUP_US - 1);
   localparam logic [US_W-1:0] RST_LAST   = US_W'(T_RST_US - 1);
   localparam logic [US_W-1:0] CFG_LAST   = US_W'(T_CFG_US - 1);

   logic [2:0]      state_q,     state_d;
   logic [PW-1:0]   presc_q,     presc_d;
   logic [US_W-1:0] us_q,        us_d;
   logic            pwdn_q,      pwdn_d;
   logic            resetn_q,    resetn_d;
   logic            xclk_en_q,   xclk_en_d;
   logic            cfg_start_q, cfg_start_d;
   logic            ready_q,     ready_d;
   logic            err_q,       err_d;

   logic            timed_s;
   logic [US_W-1:0] limit_s;
   logic            tick_s;
   logic            expire_s;
   logic            entry_s;

   // Select whether the current state is timed and which timer value ends it.
   always_comb begin
      timed_s = 1'b0;
      limit_s = US_ZERO;
      case (state_q)
         ST_PWR_UP: begin
            timed_s = 1'b1;
            limit_s = PWUP_LAST;
         end
         ST_RST_WAIT: begin
            timed_s = 1'b1;
            limit_s = RST_LAST;
         end
         ST_CFG: begin
            timed_s = 1'b1;
            limit_s = CFG_LAST;
         end
         default: begin
            timed_s = 1'b0;
            limit_s = US_ZERO;
         end
      endcase
   end

   // One-cycle microsecond tick and end-of-interval detection for timed states.
   always_comb begin
      tick_s   = timed_s && (presc_q == PRESC_LAST);
      expire_s = tick_s && (us_q == limit_s);
   end

   // Next-state decision; stop overrides every other request, done beats timeout in CFG.
   always_comb begin
      state_d = state_q;
      if (bus.stop) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (bus.start) state_d = ST_PWR_UP;
               else           state_d = ST_OFF;
            end
            ST_PWR_UP: begin
               if (expire_s) state_d = ST_RST_WAIT;
               else          state_d = ST_PWR_UP;
            end
            ST_RST_WAIT: begin
               if (expire_s) state_d = ST_CFG;
               else          state_d = ST_RST_WAIT;
            end
            ST_CFG: begin
               if (bus.cfg_done)  state_d = ST_READY;
               else if (expire_s) state_d = ST_ERROR;
               else               state_d = ST_CFG;
            end
            ST_READY: begin
               state_d = ST_READY;
            end
            ST_ERROR: begin
               if (bus.start) state_d = ST_PWR_UP;
               else           state_d = ST_ERROR;
            end
            default: begin
               // Unused encodings fall back to the safe powered-down state.
               state_d = ST_OFF;
            end
         endcase
      end
   end

   // Prescaler and us timer: cleared on any state change and idle outside timed states.
   always_comb begin
      entry_s = (state_d != state_q);
      if (entry_s || !timed_s) begin
         presc_d = PRESC_ZERO;
         us_d    = US_ZERO;
      end else if (tick_s) begin
         presc_d = PRESC_ZERO;
         us_d    = us_q + US_ONE;
      end else begin
         presc_d = presc_q + PRESC_ONE;
         us_d    = us_q;
      end
   end

   // Pin and status values for the state being entered, so the outputs register with it.
   always_comb begin
      pwdn_d      = 1'b1;
      resetn_d    = 1'b0;
      xclk_en_d   = 1'b0;
      case (state_d)
         ST_PWR_UP: begin
            pwdn_d    = 1'b0;
            resetn_d  = 1'b0;
            xclk_en_d = 1'b1;
         end
         ST_RST_WAIT, ST_CFG, ST_READY: begin
            pwdn_d    = 1'b0;
            resetn_d  = 1'b1;
            xclk_en_d = 1'b1;
         end
         default: begin
            // OFF, ERROR and anything unexpected keep the sensor powered down.
            pwdn_d    = 1'b1;
            resetn_d  = 1'b0;
            xclk_en_d = 1'b0;
         end
      endcase
      ready_d     = (state_d == ST_READY);
      err_d       = (state_d == ST_ERROR);
      // Loader launch only on the transition into CFG, never while staying there.
      cfg_start_d = (state_d == ST_CFG) && (state_q != ST_CFG);
   end

   // State, timers and all outputs registered; reset forces the powered-down state.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= ST_OFF;
         presc_q     <= PRESC_ZERO;
         us_q        <= US_ZERO;
         pwdn_q      <= 1'b1;
         resetn_q    <= 1'b0;
         xclk_en_q   <= 1'b0;
         cfg_start_q <= 1'b0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         us_q        <= us_d;
         pwdn_q      <= pwdn_d;
         resetn_q    <= resetn_d;
         xclk_en_q   <= xclk_en_d;
         cfg_start_q <= cfg_start_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.cam_pwdn   = pwdn_q;
   assign bus.cam_resetn = resetn_q;
   assign bus.xclk_en    = xclk_en_q;
   assign bus.cfg_start  = cfg_start_q;
   assign bus.ready      = ready_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with CLKDIV=4, T_PWUP_US=3, T_RST_US=2, T_CFG_US=5.
// Expected durations: PWR_UP 12 cycles, RST_WAIT 8 cycles, CFG timeout 20 cycles.
module tb_cam_pwr_seq;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cfg_pulses = 0;
   int   n;

   cam_pwr_seq_if bus ();

   cam_pwr_seq #(
      .CLKDIV    (4),
      .T_PWUP_US (3),
      .T_RST_US  (2),
      .T_CFG_US  (5),
      .US_W      (16)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   // 10 ns system clock.
   always #5 clk_in = ~clk_in;

   // Count loader launches; each pulse is one cycle wide.
   always @(negedge clk_in) begin
      if (bus.cfg_start === 1'b1) cfg_pulses++;
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Number of consecutive sampled cycles spent in state s (bounded).
   task automatic run_len(input logic [2:0] s, output int len);
      len = 0;
      while (bus.state == s && len < 200) begin
         len++;
         step();
      end
   endtask

   task automatic check_pins(input string tag, input logic pwdn, input logic resetn, input logic xclk);
      check_val({tag, "_pwdn"},   {31'd0, bus.cam_pwdn},   {31'd0, pwdn});
      check_val({tag, "_resetn"}, {31'd0, bus.cam_resetn}, {31'd0, resetn});
      check_val({tag, "_xclk"},   {31'd0, bus.xclk_en},    {31'd0, xclk});
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.cfg_done = 1'b0;

      // 1: reset held three cycles
      repeat (3) step();
      check_val("rst_state", bus.state, 32'd0);
      check_pins("rst", 1'b1, 1'b0, 1'b0);
      check_val("rst_ready", bus.ready, 32'd0);
      check_val("rst_err", bus.err, 32'd0);
      reset = 1'b0;
      step();
      check_val("idle_off", bus.state, 32'd0);

      // 2: normal power-up with cfg_done 6 cycles after cfg_start
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_val("t2_pwrup", bus.state, 32'd1);
      check_pins("t2_pwrup", 1'b0, 1'b0, 1'b1);
      run_len(3'd1, n);
      check_val("t2_pwrup_len", n, 32'd12);
      check_val("t2_rstwait", bus.state, 32'd2);
      check_pins("t2_rstwait", 1'b0, 1'b1, 1'b1);
      run_len(3'd2, n);
      check_val("t2_rstwait_len", n, 32'd8);
      check_val("t2_cfg", bus.state, 32'd3);
      check_val("t2_cfg_start", bus.cfg_start, 32'd1);
      step();
      check_val("t2_cfg_start_drop", bus.cfg_start, 32'd0);
      repeat (5) step();
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      check_val("t2_ready_state", bus.state, 32'd4);
      check_val("t2_ready", bus.ready, 32'd1);
      repeat (4) step();
      check_val("t2_ready_hold", bus.ready, 32'd1);
      check_val("t2_pulses", cfg_pulses, 32'd1);

      // 3: stop, then power-up with no cfg_done -> timeout, then retry
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check_val("t3_stop_off", bus.state, 32'd0);
      check_val("t3_stop_ready", bus.ready, 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      run_len(3'd1, n);
      check_val("t3_pwrup_len", n, 32'd12);
      run_len(3'd2, n);
      check_val("t3_rstwait_len", n, 32'd8);
      check_val("t3_cfg_start", bus.cfg_start, 32'd1);
      run_len(3'd3, n);
      check_val("t3_cfg_len", n, 32'd20);
      check_val("t3_err_state", bus.state, 32'd5);
      check_val("t3_err", bus.err, 32'd1);
      check_pins("t3_err", 1'b1, 1'b0, 1'b0);
      check_val("t3_err_ready", bus.ready, 32'd0);
      repeat (3) step();
      check_val("t3_err_hold", bus.err, 32'd1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_val("t3_retry_state", bus.state, 32'd1);
      check_val("t3_retry_err", bus.err, 32'd0);
      check_val("t3_retry_pwdn", bus.cam_pwdn, 32'd0);
      run_len(3'd1, n);
      check_val("t3_retry_pwrup_len", n, 32'd12);
      run_len(3'd2, n);
      check_val("t3_retry_rstwait_len", n, 32'd8);
      check_val("t3_retry_cfg_start", bus.cfg_start, 32'd1);

      // 4: cfg_done on the 20th CFG cycle (the timeout cycle) -> READY
      repeat (19) step();
      check_val("t4_still_cfg", bus.state, 32'd3);
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      check_val("t4_state", bus.state, 32'd4);
      check_val("t4_ready", bus.ready, 32'd1);
      check_val("t4_err", bus.err, 32'd0);
      step();
      check_val("t4_err_hold", bus.err, 32'd0);

      // 5: stop with start in RST_WAIT 3 cycles in
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      run_len(3'd1, n);
      check_val("t5_pwrup_len", n, 32'd12);
      repeat (2) step();
      check_val("t5_in_rstwait", bus.state, 32'd2);
      bus.stop  = 1'b1;
      bus.start = 1'b1;
      step();
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      check_val("t5_stop_state", bus.state, 32'd0);
      check_pins("t5_stop", 1'b1, 1'b0, 1'b0);
      repeat (2) step();
      check_val("t5_stays_off", bus.state, 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      run_len(3'd1, n);
      check_val("t5_restart_pwrup_len", n, 32'd12);

      // 6: reset mid-CFG, cfg_done while OFF ignored
      run_len(3'd2, n);
      check_val("t6_rstwait_len", n, 32'd8);
      check_val("t6_cfg", bus.state, 32'd3);
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("t6_rst_state", bus.state, 32'd0);
      check_pins("t6_rst", 1'b1, 1'b0, 1'b0);
      bus.cfg_done = 1'b1;
      repeat (3) step();
      bus.cfg_done = 1'b0;
      check_val("t6_off_state", bus.state, 32'd0);
      check_val("t6_ready", bus.ready, 32'd0);
      check_val("t6_cfg_start", bus.cfg_start, 32'd0);
      check_val("t6_pulses", cfg_pulses, 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
